// File: rtl/acc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// acc_ctrl_unit
// Multicycle control sequencer for the 4-bit-opcode accumulator datapath.
// Owns the program counter, instruction register, Z/N flags and the
// data-memory request/acknowledge handshake. Every instruction passes through
// FETCH (latch IR) and EXEC (decode, drive strobes); memory instructions add a
// MEMW wait that lasts until mem_ack.
//
// Optional build macro: ACC_CTRL_CYCLE_CNT_EN adds a saturating 16-bit
// busy-cycle counter on output cycle_cnt.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   start      begin execution (accepted in IDLE or DONE only)
//   instr      instruction word read from ROM at pc: [8:5] opcode, [4:0] operand
//   zero_in    ALU result is zero (valid in EXEC)
//   neg_in     ALU result MSB (valid in EXEC)
//   mem_ack    data-memory completion pulse
//   pc         program counter
//   alu_op     opcode held in the IR
//   operand    IR[4:0]
//   acc_we     accumulator write strobe
//   reg_we     register-file write strobe
//   mem_req    data-memory request, held until acknowledged
//   mem_we     1 = store, 0 = load, valid with mem_req
//   flag_z     registered zero flag
//   flag_n     registered negative flag
//   busy       high in FETCH, EXEC, MEMW
//   done       high in DONE
//   cycle_cnt  busy-cycle counter (only with ACC_CTRL_CYCLE_CNT_EN)
// -----------------------------------------------------------------------------
module acc_ctrl_unit #(
  parameter int PC_W     = 8,
  parameter int START_PC = 0
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic [8:0]      instr,
  input  logic            zero_in,
  input  logic            neg_in,
  input  logic            mem_ack,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      alu_op,
  output logic [4:0]      operand,
  output logic            acc_we,
  output logic            reg_we,
  output logic            mem_req,
  output logic            mem_we,
  output logic            flag_z,
  output logic            flag_n,
  output logic            busy,
  output logic            done
`ifdef ACC_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0]     cycle_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEMW  = 3'd3,
    DONE  = 3'd4
  } stateT;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_XOR = 4'd3,
    OP_SHL = 4'd4,
    OP_SHR = 4'd5,
    OP_NOT = 4'd6,
    OP_LDI = 4'd7,
    OP_LDR = 4'd8,
    OP_STR = 4'd9,
    OP_MLD = 4'd10,
    OP_MST = 4'd11,
    OP_JMP = 4'd12,
    OP_BRN = 4'd13,
    OP_BRZ = 4'd14,
    OP_CLR = 4'd15
  } opT;

  localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);

  stateT           stateReg, stateNext;
  logic [PC_W-1:0] pcReg, pcNext;
  logic [8:0]      irReg;
  logic            irLoad;
  logic            flagZ, flagN, flagZNext, flagNNext;
  logic            startAccept;
  opT              opcode;
  logic [4:0]      irOperand;

  // Branch/jump offsets are two's-complement 5-bit values widened to PC_W.
  function automatic logic signed [PC_W-1:0] sextOperand(input logic signed [4:0] v);
    return {{(PC_W-5){v[4]}}, v};
  endfunction

  // PC arithmetic wraps modulo 2^PC_W; the signed offset folds in naturally.
  function automatic logic [PC_W-1:0] pcAdd(input logic [PC_W-1:0] base,
                                            input logic signed [PC_W-1:0] off);
    return base + off;
  endfunction

  assign opcode    = opT'(irReg[8:5]);
  assign irOperand = irReg[4:0];

  always_comb begin
    stateNext   = stateReg;
    pcNext      = pcReg;
    flagZNext   = flagZ;
    flagNNext   = flagN;
    irLoad      = 1'b0;
    acc_we      = 1'b0;
    reg_we      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    startAccept = 1'b0;
    case (stateReg)
      IDLE, DONE: begin
        if (start) begin
          startAccept = 1'b1;
          pcNext      = START_PC_V;
          flagZNext   = 1'b0;
          flagNNext   = 1'b0;
          stateNext   = FETCH;
        end
      end
      FETCH: begin
        irLoad    = 1'b1;
        stateNext = EXEC;
      end
      EXEC: begin
        stateNext = FETCH;
        pcNext    = pcAdd(pcReg, PC_W'(1));
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SHL, OP_SHR, OP_NOT: begin
            acc_we    = 1'b1;
            flagZNext = zero_in;
            flagNNext = neg_in;
          end
          OP_LDI, OP_LDR: acc_we = 1'b1;
          OP_STR:         reg_we = 1'b1;
          OP_MLD, OP_MST: begin
            mem_req   = 1'b1;
            mem_we    = (opcode == OP_MST);
            pcNext    = pcReg;
            stateNext = MEMW;
          end
          OP_JMP: begin
            // A jump to itself is the halt idiom: park in DONE without refetching.
            if (irOperand == 5'd0) begin
              pcNext    = pcReg;
              stateNext = DONE;
            end else begin
              pcNext = pcAdd(pcReg, sextOperand(irOperand));
            end
          end
          OP_BRN: if (flagN) pcNext = pcAdd(pcReg, sextOperand(irOperand));
          OP_BRZ: if (flagZ) pcNext = pcAdd(pcReg, sextOperand(irOperand));
          OP_CLR: begin
            flagZNext = 1'b0;
            flagNNext = 1'b0;
          end
          default: ;
        endcase
      end
      MEMW: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_MST);
        if (mem_ack) begin
          acc_we    = (opcode == OP_MLD);
          pcNext    = pcAdd(pcReg, PC_W'(1));
          stateNext = FETCH;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      stateReg <= IDLE;
      pcReg    <= START_PC_V;
      irReg    <= '0;
      flagZ    <= 1'b0;
      flagN    <= 1'b0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      flagZ    <= flagZNext;
      flagN    <= flagNNext;
      if (irLoad) irReg <= instr;
    end
  end

  assign pc      = pcReg;
  assign alu_op  = irReg[8:5];
  assign operand = irOperand;
  assign flag_z  = flagZ;
  assign flag_n  = flagN;
  assign busy    = (stateReg == FETCH) || (stateReg == EXEC) || (stateReg == MEMW);
  assign done    = (stateReg == DONE);

`ifdef ACC_CTRL_CYCLE_CNT_EN
  logic [15:0] cycCnt;

  always_ff @(posedge CLK) begin
    if (reset || startAccept) begin
      cycCnt <= '0;
    end else if (busy && (cycCnt != 16'hFFFF)) begin
      cycCnt <= cycCnt + 16'd1;
    end
  end

  assign cycle_cnt = cycCnt;
`else
  logic unusedStartAccept;
  assign unusedStartAccept = startAccept;
`endif

endmodule

// File: tb/tb_acc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_acc_ctrl_unit
// Self-checking bench for acc_ctrl_unit: directed decode table, hand-written
// multi-cycle sequences, and a random program run against an instruction-level
// model of the machine (architectural pc/flags only).
// -----------------------------------------------------------------------------
module tb_acc_ctrl_unit;

  logic       CLK = 1'b0;
  logic       reset, start, zero_in, neg_in, mem_ack;
  logic [8:0] instr;
  logic [7:0] pc;
  logic [3:0] alu_op;
  logic [4:0] operand;
  logic       acc_we, reg_we, mem_req, mem_we, flag_z, flag_n, busy, done;
`ifdef ACC_CTRL_CYCLE_CNT_EN
  logic [15:0] cycleCnt;
`endif

  logic [8:0] rom [0:255];
  assign instr = rom[pc];

  always #5 CLK = ~CLK;

  acc_ctrl_unit #(.PC_W(8), .START_PC(0)) dut (
    .CLK(CLK), .reset(reset), .start(start), .instr(instr),
    .zero_in(zero_in), .neg_in(neg_in), .mem_ack(mem_ack),
    .pc(pc), .alu_op(alu_op), .operand(operand), .acc_we(acc_we),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
    .flag_z(flag_z), .flag_n(flag_n), .busy(busy), .done(done)
`ifdef ACC_CTRL_CYCLE_CNT_EN
    , .cycle_cnt(cycleCnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observations captured by execOne.
  logic eAcc, eReg, eMr, eMw, ackAcc, accOther, memWeBad;
  logic [3:0] eOp;
  logic [4:0] eOpd;
  int memCycles;

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = {4'd15, 5'd0};
  endtask

  task automatic doReset();
    @(negedge CLK);
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; zero_in = 1'b0; neg_in = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    #1;
  endtask

  // Leaves the bench 1 time unit after the negedge of the FETCH cycle.
  task automatic doStart();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    #1;
  endtask

  // Entered in a FETCH cycle; runs one instruction and returns positioned in
  // the following cycle (FETCH or DONE). ackN = MEMW cycle that sees mem_ack.
  task automatic execOne(input logic z, input logic n, input int ackN);
    @(negedge CLK); zero_in = z; neg_in = n; #1;
    eAcc = acc_we; eReg = reg_we; eMr = mem_req; eMw = mem_we;
    eOp = alu_op; eOpd = operand;
    memCycles = 0; memWeBad = 1'b0; ackAcc = 1'b0; accOther = 1'b0;
    if (eMr) begin
      for (int i = 1; i <= ackN; i++) begin
        @(negedge CLK); zero_in = 1'b0; neg_in = 1'b0; mem_ack = (i == ackN); #1;
        if (mem_req) memCycles++;
        if (mem_we !== eMw) memWeBad = 1'b1;
        if (i == ackN) ackAcc = acc_we;
        else if (acc_we) accOther = 1'b1;
      end
    end
    @(negedge CLK); mem_ack = 1'b0; zero_in = 1'b0; neg_in = 1'b0; #1;
  endtask

  // ---------------- instruction-level reference model ----------------
  int   mPc;
  logic mFz, mFn;
  logic xAcc, xReg, xMr, xMw, xAck;

  function automatic int wrap(input int v);
    return ((v % 256) + 256) % 256;
  endfunction

  task automatic modelStep(input logic [8:0] ins, input logic z, input logic n);
    int op, off;
    op  = int'(ins[8:5]);
    off = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
    xAcc = 0; xReg = 0; xMr = 0; xMw = 0; xAck = 0;
    if (op <= 6) begin
      xAcc = 1; mFz = z; mFn = n; mPc = wrap(mPc + 1);
    end else if (op == 7 || op == 8) begin
      xAcc = 1; mPc = wrap(mPc + 1);
    end else if (op == 9) begin
      xReg = 1; mPc = wrap(mPc + 1);
    end else if (op == 10 || op == 11) begin
      xMr = 1; xMw = (op == 11); xAck = (op == 10); mPc = wrap(mPc + 1);
    end else if (op == 12) begin
      if (off != 0) mPc = wrap(mPc + off);
    end else if (op == 13) begin
      mPc = mFn ? wrap(mPc + off) : wrap(mPc + 1);
    end else if (op == 14) begin
      mPc = mFz ? wrap(mPc + off) : wrap(mPc + 1);
    end else begin
      mFz = 0; mFn = 0; mPc = wrap(mPc + 1);
    end
  endtask

  // ---------------- directed decode table ----------------
  typedef struct {
    logic [8:0] ins;
    logic z, n;
    logic acc, rg, mr, mw, ack;
    int   nextPc;
    logic fz, fn;
  } vecT;

  vecT vecs [17];

  initial begin
    logic [8:0] ins;
    logic z, n;
    int   ackN;

    vecs[0]  = '{{4'd0,  5'd1},  0, 1, 1, 0, 0, 0, 0, 1,   0, 1};
    vecs[1]  = '{{4'd1,  5'd2},  1, 0, 1, 0, 0, 0, 0, 1,   1, 0};
    vecs[2]  = '{{4'd2,  5'd0},  1, 1, 1, 0, 0, 0, 0, 1,   1, 1};
    vecs[3]  = '{{4'd3,  5'd0},  1, 1, 1, 0, 0, 0, 0, 1,   1, 1};
    vecs[4]  = '{{4'd4,  5'd1},  0, 1, 1, 0, 0, 0, 0, 1,   0, 1};
    vecs[5]  = '{{4'd5,  5'd1},  1, 0, 1, 0, 0, 0, 0, 1,   1, 0};
    vecs[6]  = '{{4'd6,  5'd0},  0, 0, 1, 0, 0, 0, 0, 1,   0, 0};
    vecs[7]  = '{{4'd7,  5'd5},  1, 1, 1, 0, 0, 0, 0, 1,   0, 0};
    vecs[8]  = '{{4'd8,  5'd2},  1, 0, 1, 0, 0, 0, 0, 1,   0, 0};
    vecs[9]  = '{{4'd9,  5'd3},  1, 1, 0, 1, 0, 0, 0, 1,   0, 0};
    vecs[10] = '{{4'd10, 5'd4},  0, 0, 0, 0, 1, 0, 1, 1,   0, 0};
    vecs[11] = '{{4'd11, 5'd4},  0, 0, 0, 0, 1, 1, 0, 1,   0, 0};
    vecs[12] = '{{4'd12, 5'd31}, 0, 0, 0, 0, 0, 0, 0, 255, 0, 0};
    vecs[13] = '{{4'd12, 5'd4},  0, 0, 0, 0, 0, 0, 0, 4,   0, 0};
    vecs[14] = '{{4'd13, 5'd3},  0, 0, 0, 0, 0, 0, 0, 1,   0, 0};
    vecs[15] = '{{4'd14, 5'd30}, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0};
    vecs[16] = '{{4'd15, 5'd0},  1, 1, 0, 0, 0, 0, 0, 1,   0, 0};

    reset = 1'b1; start = 1'b0; zero_in = 1'b0; neg_in = 1'b0; mem_ack = 1'b0;
    clearRom();

    // Reset state.
    doReset();
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobes", {acc_we, reg_we, mem_req, mem_we}, 0);
    chk("rst_flags", {flag_z, flag_n}, 0);

    // Start then LDI 5: FETCH the cycle after start, acc_we in the one after.
    rom[0] = {4'd7, 5'd5};
    @(negedge CLK); start = 1'b1; #1;
    chk("start_idle_busy", busy, 0);
    @(negedge CLK); start = 1'b0; #1;
    chk("start_fetch_busy", busy, 1);
    chk("start_fetch_acc", acc_we, 0);
    @(negedge CLK); #1;
    chk("start_exec_acc", acc_we, 1);
    chk("start_exec_op", alu_op, 7);

    // Decode table.
    foreach (vecs[i]) begin
      clearRom();
      rom[0] = vecs[i].ins;
      doReset();
      doStart();
      execOne(vecs[i].z, vecs[i].n, 1);
      chk($sformatf("tbl%0d_op", i), eOp, vecs[i].ins[8:5]);
      chk($sformatf("tbl%0d_opd", i), eOpd, vecs[i].ins[4:0]);
      chk($sformatf("tbl%0d_strobes", i), {eAcc, eReg, eMr, eMw},
          {vecs[i].acc, vecs[i].rg, vecs[i].mr, vecs[i].mw});
      chk($sformatf("tbl%0d_ackacc", i), ackAcc, vecs[i].ack);
      chk($sformatf("tbl%0d_pc", i), pc, vecs[i].nextPc);
      chk($sformatf("tbl%0d_flags", i), {flag_z, flag_n}, {vecs[i].fz, vecs[i].fn});
    end

    // ALU + flags + taken branch + CLR.
    clearRom();
    rom[0] = {4'd7, 5'd0}; rom[1] = {4'd0, 5'd1}; rom[2] = {4'd13, 5'd3};
    rom[5] = {4'd15, 5'd0};
    doReset(); doStart();
    execOne(0, 0, 1);
    execOne(0, 1, 1);
    chk("alu_flag_n", flag_n, 1);
    chk("alu_pc2", pc, 2);
    execOne(0, 0, 1);
    chk("brn_taken_pc", pc, 5);
    execOne(1, 1, 1);
    chk("clr_flag_n", flag_n, 0);
    chk("clr_pc", pc, 6);

    // PC wrap: JMP -1 from 0 to 255, BRZ -2 not taken wraps to 0.
    clearRom();
    rom[0] = {4'd12, 5'd31}; rom[255] = {4'd14, 5'd30};
    doReset(); doStart();
    execOne(0, 0, 1);
    chk("jmp_back_255", pc, 255);
    execOne(0, 0, 1);
    chk("brz_wrap_0", pc, 0);

    // JMP -1 at pc 3.
    clearRom();
    rom[0] = {4'd12, 5'd3}; rom[3] = {4'd12, 5'd31};
    doReset(); doStart();
    execOne(0, 0, 1);
    chk("jmp_fwd_3", pc, 3);
    execOne(0, 0, 1);
    chk("jmp_m1_2", pc, 2);

    // Memory handshake: MLD acked in third wait cycle, then MST.
    clearRom();
    rom[0] = {4'd10, 5'd2}; rom[1] = {4'd11, 5'd3};
    doReset(); doStart();
    execOne(0, 0, 3);
    chk("mld_req_cycles", memCycles + int'(eMr), 4);
    chk("mld_we", eMw, 0);
    chk("mld_we_stable", memWeBad, 0);
    chk("mld_acc_ack", ackAcc, 1);
    chk("mld_acc_early", accOther | eAcc, 0);
    chk("mld_next_pc", pc, 1);
    chk("mld_next_fetch", busy, 1);
    execOne(0, 0, 2);
    chk("mst_we", eMw, 1);
    chk("mst_we_stable", memWeBad, 0);
    chk("mst_no_acc", ackAcc | accOther, 0);
    chk("mst_req_cycles", memCycles + int'(eMr), 3);
    chk("mst_next_pc", pc, 2);

    // Halt: JMP 0 at pc 7.
    clearRom();
    rom[0] = {4'd12, 5'd7}; rom[7] = {4'd12, 5'd0};
    doReset(); doStart();
    execOne(0, 0, 1);
    execOne(0, 0, 1);
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    begin
      int held = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge CLK); mem_ack = (i == 4); #1;
        if (pc == 8'd7 && done && !busy && !acc_we) held++;
      end
      mem_ack = 1'b0;
      chk("halt_hold10", held, 10);
    end
    doStart();
    chk("restart_pc", pc, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);

    // Reset during MEMW.
    clearRom();
    rom[0] = {4'd7, 5'd1}; rom[1] = {4'd10, 5'd4};
    doReset(); doStart();
    execOne(0, 0, 1);
    @(negedge CLK); #1;
    chk("mid_exec_req", mem_req, 1);
    @(negedge CLK); reset = 1'b1; #1;
    chk("mid_memw_req", mem_req, 1);
    @(negedge CLK); reset = 1'b0; #1;
    chk("mid_abort_req", mem_req, 0);
    chk("mid_abort_pc", pc, 0);
    chk("mid_abort_busy", busy, 0);
    @(negedge CLK); mem_ack = 1'b1; #1;
    chk("late_ack_acc", acc_we, 0);
    @(negedge CLK); mem_ack = 1'b0; #1;
    chk("late_ack_state", {busy, done, mem_req}, 0);
    chk("late_ack_pc", pc, 0);

    // Random program against the instruction-level model.
    for (int i = 0; i < 256; i++) begin
      rom[i] = 9'($urandom);
      if (rom[i][8:5] == 4'd12 && rom[i][4:0] == 5'd0) rom[i][4:0] = 5'd1;
    end
    doReset(); doStart();
    mPc = 0; mFz = 0; mFn = 0;
    begin
      int bad = 0;
      for (int k = 0; k < 400; k++) begin
        ins  = rom[mPc];
        z    = 1'($urandom);
        n    = 1'($urandom);
        ackN = $urandom_range(1, 3);
        if (int'(pc) != mPc) bad++;
        modelStep(ins, z, n);
        execOne(z, n, ackN);
        if (eOp != ins[8:5] || eOpd != ins[4:0]) bad++;
        if ({eAcc, eReg, eMr, eMw} != {xAcc, xReg, xMr, xMw}) bad++;
        if (xMr && (memCycles != ackN || memWeBad || ackAcc != xAck || accOther)) bad++;
        if (int'(pc) != mPc || flag_z != mFz || flag_n != mFn || !busy) bad++;
        if (bad != 0 && k < 400) begin
          chk($sformatf("rnd_step%0d_pc", k), pc, mPc);
          chk($sformatf("rnd_step%0d_flags", k), {flag_z, flag_n}, {mFz, mFn});
          chk($sformatf("rnd_step%0d_strobes", k), {eAcc, eReg, eMr, eMw},
              {xAcc, xReg, xMr, xMw});
          break;
        end
      end
      chk("rnd_steps_bad", bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
